gain_offset_calibrator: RTL and testbench
=========================================

# gain_offset_calibrator

Two-point calibration engine that produces the per-channel offset and gain bytes consumed by the RAM-dump gain correction path. It averages raw ADC samples taken at a low (zero-level) and a high reference level, then derives the signed offset and unsigned gain (0x80 = unity) so that the correction path maps the high reference to HI_TARGET. It writes both bytes to EEPROM through a ready/valid write port. It sits between the command processor, the ADC sample stream and the EEPROM controller.

## Interface
- AVG_LOG2, 4, log2 of the number of samples averaged per point (16)
- LO_TARGET, 8'h00, code the low reference must map to after offset
- HI_TARGET, 8'hC0, code the high reference must map to after offset and gain
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ch  in  2  channel select; latched on start_lo
- start_lo  in  1  pulse: begin low-point acquisition
- start_hi  in  1  pulse: begin high-point acquisition
- smpl_vld  in  1  smpl valid this cycle
- smpl  in  8  raw unsigned ADC sample
- ee_rdy  in  1  EEPROM controller accepts a write
- ee_wr  out  1  write request (valid)
- ee_addr  out  3  {ch, 0} = offset byte, {ch, 1} = gain byte
- ee_wdata  out  8  write data
- busy  out  1  high in every state except IDLE and WAIT_HI
- wait_hi  out  1  high in WAIT_HI
- done  out  1  one-cycle pulse when the gain write is accepted
- err  out  1  sticky until next start_lo; set when gain was clamped or the divisor was 0
- offset  out  8  last computed offset, two's complement
- gain  out  8  last computed gain

## Operation
- FSM states: IDLE, ACC_LO, WAIT_HI, ACC_HI, SUM, DIV, WR_OFF, WR_GAIN.
- IDLE or WAIT_HI + start_lo -> ACC_LO:
  - clears the accumulator, sample count and err
  - latches ch
  - start_lo in any other state is ignored.
- ACC_LO: add smpl on each smpl_vld; after 2^AVG_LOG2 accepted samples, go to WAIT_HI.
  - Accumulator width is 8+AVG_LOG2; no overflow is possible.
  - avg_lo = acc >> AVG_LOG2 (truncate).
  - offset_next = LO_TARGET - avg_lo as 9-bit signed, saturated to [-128, 127].
  - offset updates on this transition.
- WAIT_HI + start_hi -> ACC_HI. start_hi in any other state is ignored.
- ACC_HI: same averaging as ACC_LO, giving avg_hi; then go to SUM.
- SUM (1 cycle): s = avg_hi + offset, with exactly the correction-path saturation:
  - offset ≥ 0, avg_hi[7] = 1, sum[7] = 0 -> 0xFF
  - offset < 0, avg_hi[7] = 0, sum[7] = 1 -> 0x00
  - otherwise the 8-bit sum.
- DIV: unsigned restoring division q = (HI_TARGET << 7) / s.
  - 15-bit numerator, 8-bit divisor, 15 cycles, one quotient bit per cycle, MSB first.
  - s = 0: gain = 0xFF and err = 1.
  - q > 255: gain = 0xFF and err = 1.
  - otherwise gain = q[7:0].
  - gain updates on the exit from DIV.
- WR_OFF: ee_wr = 1, ee_addr = {ch, 0}, ee_wdata = offset. Leave when ee_wr && ee_rdy.
- WR_GAIN: ee_wr = 1, ee_addr = {ch, 1}, ee_wdata = gain. When ee_wr && ee_rdy: done = 1 for that cycle, next state IDLE.
- While ee_wr is high and ee_rdy is low, ee_addr and ee_wdata are held stable. ee_wr never drops without a handshake.
- smpl_vld is ignored outside ACC_LO and ACC_HI.

## Timing
- Reset values:
  - state IDLE
  - ee_wr, busy, wait_hi, done, err = 0
  - ee_addr, ee_wdata = 0
  - offset = 0x00, gain = 0x80
- Reset asserted in any state (including mid-ACC or mid-write) returns to these values on the next clk edge. No further EEPROM write is issued.
- start_lo at edge t: busy = 1 from t+1.
- The Nth valid sample at edge t: wait_hi = 1 (low point) or state SUM (high point) from t+1.
- High-point latency:
  - last sample accepted at edge t
  - SUM at t+1, DIV at t+2..t+16
  - ee_wr first high at t+17; with ee_rdy held high, done pulses at t+18.
- start_lo and start_hi in the same cycle while in WAIT_HI: start_lo wins (restart).

## Structure
- Package cal_pkg holds:
  - the state enum
  - the EEPROM address encoding (offset at LSB 0, gain at LSB 1)
  - unity gain constant 8'h80
  - the saturating-add function shared with the correction path.
- Sub-module cal_divider: start/busy/done handshake with a 15-bit numerator, 8-bit divisor, 15-bit quotient and a div-by-zero flag.

## Test plan
- Offset and gain from a normal two-point run:
  - stimulus: 16 low samples 0x10, then 16 high samples 0xA0 (defaults)
  - required: offset 0xF0, s = 0x90, gain 0xAA
  - required writes: (addr {ch,0}, 0xF0), then ({ch,1}, 0xAA); done pulses; err = 0.
- Unity gain: low 0x00 ×16, high 0xC0 ×16 -> offset 0x00, gain 0x80, err = 0.
- Gain clamp: low 0x00, high 0x60 -> quotient 256 -> gain 0xFF, err = 1.
- Offset saturation and zero divisor: low 0xFF, high 0x00 -> offset 0x80 (-128), s = 0x00, gain 0xFF, err = 1.
- Averaging with gaps:
  - 16 samples alternating 0x10/0x11, with smpl_vld deasserted every other cycle
  - required: avg 0x10 (truncation) and exactly 16 samples counted.
- EEPROM backpressure:
  - hold ee_rdy = 0 for 5 cycles in WR_OFF -> ee_wr, ee_addr and ee_wdata stay stable.
  - Separately, assert rst during ACC_HI -> no ee_wr, offset 0x00, gain 0x80, state IDLE next cycle.

Source files
------------

// File: rtl/cal_pkg.sv
// Shared types and helpers for the two-point gain/offset calibrator.
// sat_add matches the saturating add used by the downstream correction path.
package cal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC_LO,
    ST_WAIT_HI,
    ST_ACC_HI,
    ST_SUM,
    ST_DIV,
    ST_WR_OFF,
    ST_WR_GAIN
  } state_t;

  localparam int unsigned DIV_NUM_W = 15;
  localparam int unsigned DIV_DEN_W = 8;

  localparam logic       EE_LSB_OFF  = 1'b0;
  localparam logic       EE_LSB_GAIN = 1'b1;
  localparam logic [7:0] GAIN_UNITY  = 8'h80;
  localparam logic [7:0] GAIN_MAX    = 8'hFF;

  function automatic logic [2:0] ee_addr_enc(input logic [1:0] ch, input logic lsb);
    return {ch, lsb};
  endfunction

  // Unsigned sample plus signed offset, clamped instead of wrapping.
  function automatic logic [7:0] sat_add(input logic [7:0] smp, input logic [7:0] off);
    logic [7:0] sum;
    sum = smp + off;
    if (!off[7] && smp[7] && !sum[7])
      return 8'hFF;
    else if (off[7] && !smp[7] && sum[7])
      return 8'h00;
    else
      return sum;
  endfunction

  function automatic logic [7:0] sat_offset(input logic [7:0] target, input logic [7:0] avg);
    logic signed [8:0] diff;
    diff = $signed({1'b0, target}) - $signed({1'b0, avg});
    if (diff > 9'sd127)
      return 8'h7F;
    else if (diff < -9'sd128)
      return 8'h80;
    else
      return diff[7:0];
  endfunction

endpackage

// File: rtl/cal_divider.sv
// Restoring divider, one quotient bit per cycle MSB first; the first bit is
// produced on the start cycle so a DIV_NUM_W-bit quotient takes DIV_NUM_W cycles.
module cal_divider
  import cal_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [DIV_NUM_W-1:0] i_num,
  input  logic [DIV_DEN_W-1:0] i_den,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_dz,
  output logic [DIV_NUM_W-1:0] o_quo
);

  localparam int unsigned CNT_W = $clog2(DIV_NUM_W);

  logic [DIV_DEN_W-1:0] r_rem;
  logic [DIV_DEN_W-1:0] r_den;
  logic [DIV_NUM_W-1:0] r_num;
  logic [DIV_NUM_W-1:0] r_quo;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_dz;

  logic                 w_load;
  logic [DIV_DEN_W-1:0] w_rem_in;
  logic [DIV_DEN_W-1:0] w_den;
  logic [DIV_NUM_W-1:0] w_num_in;
  logic [DIV_NUM_W-1:0] w_quo_in;
  logic [DIV_DEN_W:0]   w_trial;
  logic                 w_ge;
  logic [DIV_DEN_W-1:0] w_rem_next;

  // One restoring step, fed either from the inputs (start) or the registers.
  always_comb begin
    w_load     = i_start && !r_busy;
    w_rem_in   = w_load ? '0 : r_rem;
    w_den      = w_load ? i_den : r_den;
    w_num_in   = w_load ? i_num : r_num;
    w_quo_in   = w_load ? '0 : r_quo;
    w_trial    = {w_rem_in, w_num_in[DIV_NUM_W-1]};
    w_ge       = w_trial >= {1'b0, w_den};
    w_rem_next = w_ge ? DIV_DEN_W'(w_trial - {1'b0, w_den}) : DIV_DEN_W'(w_trial);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_den  <= '0;
      r_num  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load || r_busy) begin
        r_rem <= w_rem_next;
        r_num <= {w_num_in[DIV_NUM_W-2:0], 1'b0};
        r_quo <= {w_quo_in[DIV_NUM_W-2:0], w_ge};
      end
      if (w_load) begin
        r_den  <= i_den;
        r_dz   <= (i_den == '0);
        r_cnt  <= CNT_W'(DIV_NUM_W - 1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_dz   = r_dz;
  assign o_quo  = r_quo;

endmodule

// File: rtl/gain_offset_calibrator.sv
// Two-point calibration: averages low/high reference samples, derives the
// signed offset and unsigned gain (0x80 = unity) and writes both to EEPROM.
module gain_offset_calibrator
  import cal_pkg::*;
#(
  parameter int unsigned AVG_LOG2  = 4,
  parameter logic [7:0]  LO_TARGET = 8'h00,
  parameter logic [7:0]  HI_TARGET = 8'hC0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ch,
  input  logic       start_lo,
  input  logic       start_hi,
  input  logic       smpl_vld,
  input  logic [7:0] smpl,
  input  logic       ee_rdy,
  output logic       ee_wr,
  output logic [2:0] ee_addr,
  output logic [7:0] ee_wdata,
  output logic       busy,
  output logic       wait_hi,
  output logic       done,
  output logic       err,
  output logic [7:0] offset,
  output logic [7:0] gain
);

  localparam int unsigned          ACC_W   = 8 + AVG_LOG2;
  localparam logic [DIV_NUM_W-1:0] DIV_NUM = {HI_TARGET, 7'b0};

  state_t              r_state;
  logic [1:0]          r_ch;
  logic [ACC_W-1:0]    r_acc;
  logic [AVG_LOG2-1:0] r_cnt;
  logic [7:0]          r_avg_hi;
  logic [7:0]          r_offset;
  logic [7:0]          r_gain;
  logic                r_err;
  logic                r_busy;
  logic                r_wait_hi;
  logic                r_ee_wr;
  logic [2:0]          r_ee_addr;
  logic [7:0]          r_ee_wdata;

  logic [ACC_W-1:0]     w_acc_next;
  logic [7:0]           w_avg;
  logic                 w_last;
  logic [7:0]           w_sum;
  logic                 w_div_start;
  logic                 w_div_busy;
  logic                 w_div_done;
  logic                 w_div_dz;
  logic [DIV_NUM_W-1:0] w_quo;
  logic                 w_gain_bad;

  always_comb begin
    w_acc_next  = r_acc + ACC_W'(smpl);
    w_avg       = w_acc_next[ACC_W-1:AVG_LOG2];
    w_last      = (r_cnt == '1);
    w_sum       = sat_add(r_avg_hi, r_offset);
    w_div_start = (r_state == ST_SUM) && !w_div_busy;
    w_gain_bad  = w_div_dz || (w_quo[DIV_NUM_W-1:8] != '0);
  end

  cal_divider u_div (
    .clk    (clk),
    .rst    (rst),
    .i_start(w_div_start),
    .i_num  (DIV_NUM),
    .i_den  (w_sum),
    .o_busy (w_div_busy),
    .o_done (w_div_done),
    .o_dz   (w_div_dz),
    .o_quo  (w_quo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ch       <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_avg_hi   <= '0;
      r_offset   <= 8'h00;
      r_gain     <= GAIN_UNITY;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_wait_hi  <= 1'b0;
      r_ee_wr    <= 1'b0;
      r_ee_addr  <= '0;
      r_ee_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_WAIT_HI: begin
          // start_lo has priority and restarts from WAIT_HI
          if (start_lo) begin
            r_state   <= ST_ACC_LO;
            r_ch      <= ch;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b1;
            r_wait_hi <= 1'b0;
          end else if (r_state == ST_WAIT_HI && start_hi) begin
            r_state   <= ST_ACC_HI;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_wait_hi <= 1'b0;
          end
        end
        ST_ACC_LO: begin
          if (smpl_vld) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + AVG_LOG2'(1);
            if (w_last) begin
              r_offset  <= sat_offset(LO_TARGET, w_avg);
              r_state   <= ST_WAIT_HI;
              r_busy    <= 1'b0;
              r_wait_hi <= 1'b1;
            end
          end
        end
        ST_ACC_HI: begin
          if (smpl_vld) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + AVG_LOG2'(1);
            if (w_last) begin
              r_avg_hi <= w_avg;
              r_state  <= ST_SUM;
            end
          end
        end
        ST_SUM: begin
          if (!w_div_busy) r_state <= ST_DIV;
        end
        ST_DIV: begin
          if (w_div_done) begin
            r_gain     <= w_gain_bad ? GAIN_MAX : w_quo[7:0];
            if (w_gain_bad) r_err <= 1'b1;
            r_state    <= ST_WR_OFF;
            r_ee_wr    <= 1'b1;
            r_ee_addr  <= ee_addr_enc(r_ch, EE_LSB_OFF);
            r_ee_wdata <= r_offset;
          end
        end
        ST_WR_OFF: begin
          if (ee_rdy) begin
            r_state    <= ST_WR_GAIN;
            r_ee_addr  <= ee_addr_enc(r_ch, EE_LSB_GAIN);
            r_ee_wdata <= r_gain;
          end
        end
        ST_WR_GAIN: begin
          if (ee_rdy) begin
            r_state <= ST_IDLE;
            r_ee_wr <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // done marks the accepting cycle of the gain write
  assign done     = (r_state == ST_WR_GAIN) && ee_rdy;
  assign ee_wr    = r_ee_wr;
  assign ee_addr  = r_ee_addr;
  assign ee_wdata = r_ee_wdata;
  assign busy     = r_busy;
  assign wait_hi  = r_wait_hi;
  assign err      = r_err;
  assign offset   = r_offset;
  assign gain     = r_gain;

endmodule

// File: tb/tb_gain_offset_calibrator.sv
// Randomized and directed two-point calibration runs against an arithmetic
// reference model of averaging, offset, saturated sum and gain division.
module tb_gain_offset_calibrator;

  localparam int N    = 16;
  localparam int LO_T = 0;
  localparam int HI_T = 192;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] ch = '0;
  logic       start_lo = 1'b0;
  logic       start_hi = 1'b0;
  logic       smpl_vld = 1'b0;
  logic [7:0] smpl = '0;
  logic       ee_rdy = 1'b0;
  logic       ee_wr;
  logic [2:0] ee_addr;
  logic [7:0] ee_wdata;
  logic       busy;
  logic       wait_hi;
  logic       done;
  logic       err;
  logic [7:0] offset;
  logic [7:0] gain;

  always #5 clk = ~clk;

  gain_offset_calibrator dut (
    .clk     (clk),
    .rst     (rst),
    .ch      (ch),
    .start_lo(start_lo),
    .start_hi(start_hi),
    .smpl_vld(smpl_vld),
    .smpl    (smpl),
    .ee_rdy  (ee_rdy),
    .ee_wr   (ee_wr),
    .ee_addr (ee_addr),
    .ee_wdata(ee_wdata),
    .busy    (busy),
    .wait_hi (wait_hi),
    .done    (done),
    .err     (err),
    .offset  (offset),
    .gain    (gain)
  );

  int checks = 0;
  int errors = 0;
  int lo_s[N];
  int hi_s[N];
  logic [15:0] wq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every accepted EEPROM write, in order
  always @(negedge clk)
    if (ee_wr === 1'b1 && ee_rdy === 1'b1) wq.push_back({5'b0, ee_addr, ee_wdata});

  task automatic model(output int e_off, output int e_gain, output int e_err);
    int sl, sh, o, s, q;
    sl = 0; sh = 0;
    for (int i = 0; i < N; i++) begin
      sl += lo_s[i];
      sh += hi_s[i];
    end
    o = LO_T - sl / N;
    if (o > 127) o = 127;
    if (o < -128) o = -128;
    s = sh / N + o;
    if (s > 255) s = 255;
    if (s < 0) s = 0;
    e_err = 0;
    if (s == 0) begin
      e_gain = 255; e_err = 1;
    end else begin
      q = (HI_T * 128) / s;
      if (q > 255) begin
        e_gain = 255; e_err = 1;
      end else e_gain = q;
    end
    e_off = o & 255;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit lo, input bit hi);
    tick();
    start_lo = lo; start_hi = hi;
    tick();
    start_lo = 1'b0; start_hi = 1'b0;
  endtask

  // Returns #1 after the edge that accepts the last sample
  task automatic feed(input bit high, input bit gaps);
    for (int i = 0; i < N; i++) begin
      tick();
      smpl_vld = 1'b1;
      smpl = 8'(high ? hi_s[i] : lo_s[i]);
      if (gaps) begin
        tick();
        smpl_vld = 1'b0;
        smpl = 8'hFF;
      end
    end
    if (!gaps) begin
      tick();
      smpl_vld = 1'b0;
    end
  endtask

  task automatic run(input string nm, input int chv, input bit gaps, input int bp, input bit restart);
    int e_off, e_gain, e_err, n, cyc;
    model(e_off, e_gain, e_err);
    wq.delete();
    ee_rdy = (bp == 0);
    ch = 2'(chv);
    pulse(1'b1, 1'b0);
    ch = 2'($urandom);
    @(negedge clk);
    check({nm, "_busy_start"}, busy, 1);
    check({nm, "_err_clr"}, err, 0);
    feed(1'b0, gaps);
    @(negedge clk);
    check({nm, "_wait_hi"}, wait_hi, 1);
    check({nm, "_busy_wait"}, busy, 0);
    check({nm, "_offset"}, offset, e_off);
    if (restart) begin
      ch = 2'(chv);
      pulse(1'b1, 1'b1);
      ch = 2'($urandom);
      @(negedge clk);
      check({nm, "_restart_busy"}, busy, 1);
      check({nm, "_restart_wait"}, wait_hi, 0);
      feed(1'b0, gaps);
      @(negedge clk);
      check({nm, "_wait_hi2"}, wait_hi, 1);
    end
    tick();
    smpl_vld = 1'b1; smpl = 8'($urandom);
    tick();
    smpl_vld = 1'b0;
    pulse(1'b0, 1'b1);
    @(negedge clk);
    check({nm, "_busy_hi"}, busy, 1);
    feed(1'b1, gaps);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      n = k;
      if (ee_wr === 1'b1) break;
    end
    check({nm, "_wr_latency"}, n, 17);
    check({nm, "_addr_off"}, ee_addr, {chv[1:0], 1'b0});
    check({nm, "_wdata_off"}, ee_wdata, e_off);
    cyc = n;
    if (bp > 0) begin
      for (int k = 0; k < bp; k++) begin
        @(negedge clk);
        cyc++;
        check({nm, "_bp_wr"}, ee_wr, 1);
        check({nm, "_bp_addr"}, ee_addr, {chv[1:0], 1'b0});
        check({nm, "_bp_wdata"}, ee_wdata, e_off);
      end
      tick();
      ee_rdy = 1'b1;
    end
    while (done !== 1'b1 && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, "_done_seen"}, done, 1);
    if (bp == 0) check({nm, "_done_latency"}, cyc, 18);
    check({nm, "_addr_gain"}, ee_addr, {chv[1:0], 1'b1});
    check({nm, "_wdata_gain"}, ee_wdata, e_gain);
    @(negedge clk);
    check({nm, "_done_pulse"}, done, 0);
    check({nm, "_idle_busy"}, busy, 0);
    check({nm, "_idle_wr"}, ee_wr, 0);
    check({nm, "_gain"}, gain, e_gain);
    check({nm, "_err"}, err, e_err);
    check({nm, "_nwrites"}, wq.size(), 2);
    if (wq.size() >= 2) begin
      check({nm, "_w0"}, wq[0], {5'b0, chv[1:0], 1'b0, 8'(e_off)});
      check({nm, "_w1"}, wq[1], {5'b0, chv[1:0], 1'b1, 8'(e_gain)});
    end
  endtask

  task automatic fill(input int lo, input int hi);
    for (int i = 0; i < N; i++) begin
      lo_s[i] = lo;
      hi_s[i] = hi;
    end
  endtask

  initial begin
    int lb, hb, nwr;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_wait_hi", wait_hi, 0);
    check("rst_wr", ee_wr, 0);
    check("rst_addr", ee_addr, 0);
    check("rst_wdata", ee_wdata, 0);
    check("rst_err", err, 0);
    check("rst_done", done, 0);
    check("rst_offset", offset, 8'h00);
    check("rst_gain", gain, 8'h80);

    fill(8'h10, 8'hA0);
    run("normal", 2, 1'b0, 0, 1'b0);
    check("normal_off_const", offset, 8'hF0);
    check("normal_gain_const", gain, 8'hAA);

    fill(8'h00, 8'hC0);
    run("unity", 1, 1'b0, 0, 1'b0);
    check("unity_gain_const", gain, 8'h80);

    fill(8'h00, 8'h60);
    run("clamp", 3, 1'b0, 0, 1'b0);
    check("clamp_gain_const", gain, 8'hFF);
    check("clamp_err_const", err, 1);

    fill(8'hFF, 8'h00);
    run("zero_div", 0, 1'b0, 0, 1'b0);
    check("zero_div_off_const", offset, 8'h80);
    check("zero_div_gain_const", gain, 8'hFF);
    check("zero_div_err_const", err, 1);

    fill(8'h10, 8'hA0);
    for (int i = 0; i < N; i++) lo_s[i] = (i % 2 == 0) ? 8'h10 : 8'h11;
    run("gaps", 1, 1'b1, 0, 1'b0);
    check("gaps_off_const", offset, 8'hF0);

    fill(8'h10, 8'hA0);
    run("backpr", 2, 1'b0, 5, 1'b0);

    fill(8'h20, 8'hB0);
    run("restart", 3, 1'b0, 0, 1'b1);

    for (int r = 0; r < 8; r++) begin
      lb = int'($urandom_range(0, 120));
      hb = int'($urandom_range(40, 248));
      for (int i = 0; i < N; i++) begin
        lo_s[i] = lb + int'($urandom_range(0, 7));
        hi_s[i] = hb + int'($urandom_range(0, 7));
      end
      run($sformatf("rand%0d", r), int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Reset in the middle of high-point acquisition
    fill(8'h10, 8'hA0);
    ee_rdy = 1'b1;
    ch = 2'd1;
    pulse(1'b1, 1'b0);
    feed(1'b0, 1'b0);
    pulse(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      smpl_vld = 1'b1; smpl = 8'hA0;
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_wait_hi", wait_hi, 0);
    check("midrst_wr", ee_wr, 0);
    check("midrst_offset", offset, 8'h00);
    check("midrst_gain", gain, 8'h80);
    nwr = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ee_wr !== 1'b0 || busy !== 1'b0) nwr++;
    end
    smpl_vld = 1'b0;
    check("midrst_quiet", nwr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

endmodule
